systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_skew.sv | 31 +++
 rtl/systolic_ctrl.sv | 155 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding and sequencing constants for the systolic array controller.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } ctrlState_e;

   // Skewed feed length for an n x n array: the last product meets in PE(n-1,n-1).
   function automatic int feedLen(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_skew.sv
// Combinational selection of the skewed row-edge and column-edge operands for one feed step.
module systolic_skew
   import systolic_pkg::*;
#(
   parameter int W  = 32,
   parameter int N  = 3,
   parameter int CW = 4
) (
   input  logic [W*N*N-1:0] i_matA,
   input  logic [W*N*N-1:0] i_matB,
   input  logic [CW-1:0]    i_step,
   input  logic             i_active,
   output logic [W*N-1:0]   o_rowA,
   output logic [W*N-1:0]   o_colB
);

   // Row i carries A(i,k-i) and column i carries B(k-i,i) while that index is inside the matrix.
   always_comb begin
      o_rowA = '0;
      o_colB = '0;
      if (i_active) begin
         for (int i = 0; i < N; i++) begin
            if ((int'(i_step) >= i) && (int'(i_step) - i < N)) begin
               o_rowA[i*W +: W] = i_matA[(i*N + int'(i_step) - i)*W +: W];
               o_colB[i*W +: W] = i_matB[((int'(i_step) - i)*N + i)*W +: W];
            end
         end
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequences one matrix job through a systolic array: clear, skewed feed, drain, capture, hand-off.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int W         = 32,
   parameter int N         = 3,
   parameter int DRAIN_CYC = N
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_mode,
   input  logic [W*N*N-1:0] i_A,
   input  logic [W*N*N-1:0] i_B,
   input  logic             i_stall,
   output logic             o_sa_en,
   output logic             o_sa_sync,
   output logic             o_sa_mode,
   output logic [W*N-1:0]   o_sa_A,
   output logic [W*N-1:0]   o_sa_B,
   input  logic [W*N*N-1:0] i_sa_C,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [W*N*N-1:0] o_res,
   output logic             o_busy
);

   localparam int CW       = $clog2(3 * N);
   localparam int FEED_LEN = feedLen(N);

   ctrlState_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W*N*N-1:0] matA_q, matB_q, res_q;
   logic [W*N-1:0]   saA_q, saA_d, saB_q, saB_d, skewA, skewB;
   logic             mode_q, en_q, sync_q, resValid_q;
   logic             accept, issue, capture, frozen;

   systolic_skew #(.W(W), .N(N), .CW(CW)) uSkew (
      .i_matA  (matA_q),
      .i_matB  (matB_q),
      .i_step  (cnt_q),
      .i_active(state_q == FEED),
      .o_rowA  (skewA),
      .o_colB  (skewB)
   );

   // The state names the step to be issued next; the registered array outputs present it one
   // cycle later, and the array consumes it on the edge after that.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      issue   = 1'b0;
      capture = 1'b0;
      frozen  = i_stall && (state_q inside {CLEAR, FEED, DRAIN});
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               accept  = 1'b1;
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (!i_stall) begin
               issue   = 1'b1;
               state_d = FEED;
               cnt_d   = '0;
            end
         end
         FEED: begin
            if (!i_stall) begin
               issue = 1'b1;
               if (cnt_q == CW'(FEED_LEN - 1)) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!i_stall) begin
               if (cnt_q == CW'(DRAIN_CYC)) begin
                  capture = 1'b1;
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  issue = 1'b1;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (i_res_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      saA_d = issue ? skewA : (frozen ? saA_q : '0);
      saB_d = issue ? skewB : (frozen ? saB_q : '0);
   end

   // State, job registers and every array-facing output live here so they clear together on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         matA_q     <= '0;
         matB_q     <= '0;
         mode_q     <= 1'b0;
         en_q       <= 1'b0;
         sync_q     <= 1'b0;
         saA_q      <= '0;
         saB_q      <= '0;
         resValid_q <= 1'b0;
         res_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= issue;
         sync_q  <= issue && (state_q == CLEAR);
         saA_q   <= saA_d;
         saB_q   <= saB_d;
         if (accept) begin
            matA_q <= i_A;
            matB_q <= i_B;
            mode_q <= i_mode;
         end
         if (capture) begin
            res_q      <= i_sa_C;
            resValid_q <= 1'b1;
         end else if ((state_q == DONE) && i_res_ready) begin
            resValid_q <= 1'b0;
         end
      end
   end

   assign o_ready     = (state_q == IDLE);
   assign o_busy      = (state_q != IDLE);
   assign o_sa_en     = en_q;
   assign o_sa_sync   = sync_q;
   assign o_sa_mode   = mode_q;
   assign o_sa_A      = saA_q;
   assign o_sa_B      = saB_q;
   assign o_res_valid = resValid_q;
   assign o_res       = res_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl wired to a behavioural output-stationary 3x3 array model.
module tb_systolic_ctrl;

   localparam int W  = 32;
   localparam int N  = 3;
   localparam int MW = W * N * N;
   localparam int RW = W * N;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_mode = 1'b0;
   logic [MW-1:0] i_A = '0;
   logic [MW-1:0] i_B = '0;
   logic          i_stall = 1'b0;
   logic          i_res_ready = 1'b0;
   logic [MW-1:0] saC;
   logic          o_ready, o_sa_en, o_sa_sync, o_sa_mode, o_res_valid, o_busy;
   logic [RW-1:0] o_sa_A, o_sa_B;
   logic [MW-1:0] o_res;

   int vecCount = 0;
   int missCount = 0;
   int syncSeen = 0;

   systolic_ctrl #(.W(W), .N(N), .DRAIN_CYC(N)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_mode     (i_mode),
      .i_A        (i_A),
      .i_B        (i_B),
      .i_stall    (i_stall),
      .o_sa_en    (o_sa_en),
      .o_sa_sync  (o_sa_sync),
      .o_sa_mode  (o_sa_mode),
      .o_sa_A     (o_sa_A),
      .o_sa_B     (o_sa_B),
      .i_sa_C     (saC),
      .o_res_valid(o_res_valid),
      .i_res_ready(i_res_ready),
      .o_res      (o_res),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Array model: A flows right, B flows down, each PE accumulates its own C element.
   logic [W-1:0] aPipe [N][N];
   logic [W-1:0] bPipe [N][N];
   logic [W-1:0] acc   [N][N];

   function automatic logic [W-1:0] aIn(input int i, input int j);
      if (j == 0) return o_sa_A[i*W +: W];
      return aPipe[i][j-1];
   endfunction

   function automatic logic [W-1:0] bIn(input int i, input int j);
      if (i == 0) return o_sa_B[j*W +: W];
      return bPipe[i-1][j];
   endfunction

   always @(posedge i_clk) begin
      if (o_sa_en) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               aPipe[i][j] <= o_sa_sync ? '0 : aIn(i, j);
               bPipe[i][j] <= o_sa_sync ? '0 : bIn(i, j);
               acc[i][j]   <= o_sa_sync ? '0 : acc[i][j] + aIn(i, j) * bIn(i, j);
            end
         end
      end
   end

   always_comb begin
      saC = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            saC[(i*N + j)*W +: W] = acc[i][j];
   end

   always @(negedge i_clk) begin
      if (o_sa_sync) syncSeen <= syncSeen + 1;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [MW-1:0] mat9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
      return {W'(e8), W'(e7), W'(e6), W'(e5), W'(e4), W'(e3), W'(e2), W'(e1), W'(e0)};
   endfunction

   function automatic logic [RW-1:0] row3(input int r0, r1, r2);
      return {W'(r2), W'(r1), W'(r0)};
   endfunction

   task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                              input logic [MW-1:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      for (int s = 0; s < n; s++) begin
         @(posedge i_clk);
         @(negedge i_clk);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                input logic m, output int waits);
      waits = 0;
      i_A = a;
      i_B = b;
      i_mode = m;
      i_valid = 1'b1;
      while (!o_ready && waits < 50) begin
         @(negedge i_clk);
         waits++;
      end
      checkOutput("acceptReady", o_ready, 1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic waitResult(output int cycles);
      cycles = 0;
      while (!o_res_valid && cycles < 100) begin
         @(posedge i_clk);
         @(negedge i_clk);
         cycles++;
      end
   endtask

   task automatic checkIdle(input string pfx);
      checkOutput({pfx, "_ready"}, o_ready, 1);
      checkOutput({pfx, "_busy"}, o_busy, 0);
      checkOutput({pfx, "_en"}, o_sa_en, 0);
      checkOutput({pfx, "_sync"}, o_sa_sync, 0);
      checkOutput({pfx, "_mode"}, o_sa_mode, 0);
      checkOutput({pfx, "_saA"}, o_sa_A, 0);
      checkOutput({pfx, "_saB"}, o_sa_B, 0);
      checkOutput({pfx, "_resValid"}, o_res_valid, 0);
      checkOutput({pfx, "_res"}, o_res, 0);
   endtask

   initial begin
      logic [MW-1:0] matI, mat19, mat2, matD, matJ, all12, expJ, expD;
      int waits, lat, extra, syncBase;
      logic sawValid;

      matI  = mat9(1, 0, 0, 0, 1, 0, 0, 0, 1);
      mat19 = mat9(1, 2, 3, 4, 5, 6, 7, 8, 9);
      mat2  = mat9(2, 2, 2, 2, 2, 2, 2, 2, 2);
      matD  = mat9(1, 0, 0, 0, 2, 0, 0, 0, 3);
      matJ  = mat9(2, 0, 1, 1, 1, 0, 0, 3, 1);
      all12 = mat9(12, 12, 12, 12, 12, 12, 12, 12, 12);
      expJ  = mat9(9, 12, 15, 5, 7, 9, 19, 23, 27);
      expD  = mat9(1, 4, 9, 4, 10, 18, 7, 16, 27);

      // Reset values, then an accept in the very first cycle after release.
      @(negedge i_clk);
      @(negedge i_clk);
      checkIdle("reset");
      i_rst_n = 1'b1;

      // Identity times 1..9, result held in DONE while a new request is ignored.
      syncBase = syncSeen;
      applyStimulus(matI, mat19, 1'b1, waits);
      checkOutput("firstAcceptWaits", waits, 0);
      checkOutput("busyAfterAccept", o_busy, 1);
      waitResult(lat);
      checkOutput("job1Latency", lat, 12);
      checkOutput("job1Result", o_res, mat19);
      checkOutput("job1SyncCount", syncSeen - syncBase, 1);
      i_valid = 1'b1;
      i_mode = 1'b0;
      i_A = mat2;
      for (int c = 0; c < 5; c++) begin
         checkOutput("holdRes", o_res, mat19);
         checkOutput("holdValid", o_res_valid, 1);
         checkOutput("holdReady", o_ready, 0);
         step(1);
      end
      i_valid = 1'b0;
      i_res_ready = 1'b1;
      step(1);
      checkOutput("releaseReady", o_ready, 1);
      checkOutput("releaseValid", o_res_valid, 0);
      checkOutput("noAcceptInDone", o_sa_mode, 1);

      // All-2s job with the next request already waiting, then back-to-back accept.
      syncBase = syncSeen;
      applyStimulus(mat2, mat2, 1'b0, waits);
      i_A = matJ;
      i_B = mat19;
      i_mode = 1'b1;
      i_valid = 1'b1;
      waitResult(lat);
      checkOutput("job2Latency", lat, 12);
      checkOutput("job2Result", o_res, all12);
      checkOutput("job2SyncCount", syncSeen - syncBase, 1);
      checkOutput("job2Mode", o_sa_mode, 0);
      step(1);
      checkOutput("b2bIdleReady", o_ready, 1);
      checkOutput("b2bIdleValid", o_res_valid, 0);
      step(1);
      checkOutput("b2bAcceptBusy", o_busy, 1);
      checkOutput("b2bModeChange", o_sa_mode, 1);
      i_valid = 1'b0;
      waitResult(lat);
      checkOutput("job3Latency", lat, 12);
      checkOutput("job3Result", o_res, expJ);

      // Three-cycle stall while feed step 2 is on the array edge.
      applyStimulus(mat19, matD, 1'b0, waits);
      step(4);
      checkOutput("stallPreEn", o_sa_en, 1);
      checkOutput("stallPreA", o_sa_A, row3(3, 5, 7));
      checkOutput("stallPreB", o_sa_B, row3(0, 2, 0));
      i_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1);
         checkOutput("stallEn", o_sa_en, 0);
         checkOutput("stallA", o_sa_A, row3(3, 5, 7));
         checkOutput("stallB", o_sa_B, row3(0, 2, 0));
      end
      i_stall = 1'b0;
      waitResult(extra);
      checkOutput("stallLatency", 7 + extra, 15);
      checkOutput("stallResult", o_res, expD);

      // Reset pulse while feed step 3 is presented.
      applyStimulus(mat2, mat2, 1'b1, waits);
      step(5);
      checkOutput("feed3En", o_sa_en, 1);
      checkOutput("feed3A", o_sa_A, row3(0, 2, 2));
      i_rst_n = 1'b0;
      #1;
      checkIdle("midReset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      sawValid = 1'b0;
      for (int c = 0; c < 14; c++) begin
         step(1);
         if (o_res_valid) sawValid = 1'b1;
      end
      checkOutput("noResAfterReset", sawValid, 0);
      checkOutput("idleAfterReset", o_busy, 0);

      // Recovery job must clear the stale partial sums of the aborted one.
      syncBase = syncSeen;
      applyStimulus(mat19, matI, 1'b0, waits);
      waitResult(lat);
      checkOutput("job6Latency", lat, 12);
      checkOutput("job6Result", o_res, mat19);
      checkOutput("job6SyncCount", syncSeen - syncBase, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
